mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer for the five-stage MIPS pipeline. It sits in the E stage, owns the HI/LO registers and sequences signed and unsigned mult/div over a fixed number of cycles. It exports `start_E`/`busy_E` to the hazard unit, which stalls D-stage MDU instructions while a sequence is pending. It also services mfhi/mflo/mthi/mtlo and drops a start that coincides with an exception flush.

---
 rtl/mdu_pkg.sv | 14 +
 rtl/mdu_arith.sv | 27 ++
 rtl/mdu_sequencer.sv | 89 ++++++++
 tb/tb_mdu_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MDU operation encodings, sequencer states and default latencies.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
        OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
    } mdu_op_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational signed/unsigned 64-bit product and truncating quotient/remainder.
module mdu_arith (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sgn_i,
    output logic [63:0] prod_o,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, uq, ur;

    // Divide magnitudes so 0x80000000 / -1 wraps to 0x80000000 without signed overflow.
    always_comb begin
        neg_a  = sgn_i & a_i[31];
        neg_b  = sgn_i & b_i[31];
        mag_a  = neg_a ? -a_i : a_i;
        mag_b  = (b_i == '0) ? 32'd1 : (neg_b ? -b_i : b_i);
        uq     = mag_a / mag_b;
        ur     = mag_a % mag_b;
        quo_o  = (neg_a ^ neg_b) ? -uq : uq;
        rem_o  = neg_a ? -ur : ur;
        prod_o = {{32{neg_a}}, a_i} * {{32{neg_b}}, b_i};
    end

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: E-stage HI/LO owner that sequences mult/div over fixed cycle counts
// and services mfhi/mflo/mthi/mtlo.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mdu_op,
    input  logic        start_E,
    input  logic        cancel,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy_E,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_rd
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   a_q, b_q, hi_q, lo_q;
    logic          sgn_q, busy_q;
    logic [63:0]   prod;
    logic [31:0]   quo, rem;
    logic          is_div;

    mdu_arith u_arith (
        .a_i    (a_q),
        .b_i    (b_q),
        .sgn_i  (sgn_q),
        .prod_o (prod),
        .quo_o  (quo),
        .rem_o  (rem)
    );

    assign is_div = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (!cancel && start_E) begin
                a_q     <= src_a;
                b_q     <= src_b;
                sgn_q   <= (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
                cnt_q   <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                state_q <= is_div ? S_DIV : S_MUL;
                busy_q  <= 1'b1;
            end else if (!cancel && mdu_op == OP_MTHI) begin
                hi_q <= src_a;
            end else if (!cancel && mdu_op == OP_MTLO) begin
                lo_q <= src_a;
            end
        end else begin
            // In-flight sequences ignore cancel/start/mt*: the instruction already committed.
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                if (state_q == S_MUL) begin
                    hi_q <= prod[63:32];
                    lo_q <= prod[31:0];
                end else if (b_q != '0) begin
                    hi_q <= rem;
                    lo_q <= quo;
                end
            end
        end
    end

    assign busy_E = busy_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign mdu_rd = (mdu_op == OP_MFHI) ? hi_q : (mdu_op == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: table-driven mult/div vectors plus hand sequences for cancel, busy-time
// starts, asynchronous reset mid-divide and back-to-back issue.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  mdu_op = OP_NONE;
    logic        start_E = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy_E;
    logic [31:0] hi, lo, mdu_rd;

    int nvec = 0;
    int nfail = 0;

    mdu_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mdu_op  (mdu_op),
        .start_E (start_E),
        .cancel  (cancel),
        .src_a   (src_a),
        .src_b   (src_b),
        .busy_E  (busy_E),
        .hi      (hi),
        .lo      (lo),
        .mdu_rd  (mdu_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        mdu_op = op; src_a = a; src_b = b; start_E = 1'b1;
        step();
        mdu_op = OP_NONE; start_E = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy_E && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        mdu_op = OP_MTHI; src_a = h; step();
        mdu_op = OP_MTLO; src_a = l; step();
        mdu_op = OP_NONE;
    endtask

    int n;

    initial begin
        vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        5,  32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFD, 32'd5,        5,  32'h00000004, 32'hFFFFFFF1};
        vecs[2] = '{OP_DIVU,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003};
        vecs[3] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{OP_DIV,   32'd5,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[6] = '{OP_DIVU,  32'h80000000, 32'hFFFFFFFF, 10, 32'h80000000, 32'h00000000};
        vecs[7] = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001};
        vecs[8] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};

        mdu_op = OP_MFHI;
        #3;
        check("reset_busy", {31'd0, busy_E}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_rd", mdu_rd, 32'd0);
        mdu_op = OP_NONE;
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_idle(n);
            check($sformatf("vec%0d_cycles", i), n, vecs[i].cyc);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
            mdu_op = OP_MFHI; #1;
            check($sformatf("vec%0d_mfhi", i), mdu_rd, vecs[i].exp_hi);
            mdu_op = OP_MFLO; #1;
            check($sformatf("vec%0d_mflo", i), mdu_rd, vecs[i].exp_lo);
            mdu_op = OP_NONE;
            step();
        end

        mdu_op = OP_MTHI; src_a = 32'h1234; step();
        mdu_op = OP_MFHI; #1;
        check("mthi_mfhi", mdu_rd, 32'h1234);
        mdu_op = OP_MTLO; src_a = 32'h5555; step();
        mdu_op = OP_MTLO; src_a = 32'hDEAD; cancel = 1'b1; step();
        cancel = 1'b0; mdu_op = OP_NONE;
        check("mtlo_cancel_lo", lo, 32'h5555);
        check("mtlo_cancel_hi", hi, 32'h1234);

        cancel = 1'b1;
        start_op(OP_MULT, 32'd3, 32'd3);
        cancel = 1'b0;
        check("start_cancel_busy", {31'd0, busy_E}, 32'd0);
        check("start_cancel_hi", hi, 32'h1234);
        check("start_cancel_lo", lo, 32'h5555);

        start_op(OP_MULT, 32'hFFFFFFFD, 32'd5);
        n = 0;
        while (busy_E && n < 200) begin
            n++;
            if (n == 3) begin
                mdu_op = OP_DIVU; src_a = 32'd100; src_b = 32'd7; start_E = 1'b1;
            end else begin
                mdu_op = OP_NONE; start_E = 1'b0;
            end
            step();
        end
        mdu_op = OP_NONE; start_E = 1'b0;
        check("busy_start_cycles", n, 32'd5);
        check("busy_start_hi", hi, 32'hFFFFFFFF);
        check("busy_start_lo", lo, 32'hFFFFFFF1);
        step();
        check("busy_start_ignored", {31'd0, busy_E}, 32'd0);

        write_hilo(32'hAAAA, 32'hBBBB);
        start_op(OP_DIVU, 32'd7, 32'd2);
        for (int i = 1; i < 6; i++) step();
        check("pre_reset_busy", {31'd0, busy_E}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_busy", {31'd0, busy_E}, 32'd0);
        check("async_reset_hi", hi, 32'd0);
        check("async_reset_lo", lo, 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("after_reset_busy", {31'd0, busy_E}, 32'd0);
        check("after_reset_hi", hi, 32'd0);
        check("after_reset_lo", lo, 32'd0);

        start_op(OP_DIV, 32'd100, 32'd7);
        wait_idle(n);
        check("b2b_div_cycles", n, 32'd10);
        check("b2b_div_hi", hi, 32'd2);
        check("b2b_div_lo", lo, 32'd14);
        start_op(OP_MULT, 32'd6, 32'd7);
        check("b2b_mult_busy", {31'd0, busy_E}, 32'd1);
        check("b2b_hold_hi", hi, 32'd2);
        check("b2b_hold_lo", lo, 32'd14);
        wait_idle(n);
        check("b2b_mult_cycles", n, 32'd5);
        check("b2b_mult_hi", hi, 32'd0);
        check("b2b_mult_lo", lo, 32'd42);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
